core_mem: RTL and testbench

// - Memory stage directly downstream of the execute stage; consumes EX_regs, produces MEM_regs for write-back.
// - Issues one data-memory request per load/store over a req/ready handshake and stalls the pipe until it completes.
// - Aligns and extends load data; supplies MEM_data, the forwarding value used by execute.

---
 rtl/core_mem_pkg.sv | 107 ++++++++++
 rtl/core_mem_load_align.sv | 33 +++
 rtl/core_mem.sv | 134 +++++++++++++
 tb/tb_core_mem.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the memory stage (core_mem).
// Holds the pipeline register layouts, the access-size and FSM state enums,
// and small per-size helpers for byte enables, alignment masks and store replication.
package core_mem_pkg;

    localparam int MEM_WORD_BYTES = 8;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        BYTE  = 3'd1,
        HALF  = 3'd2,
        WORD  = 3'd3,
        DWORD = 3'd4
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Execute-stage register: out carries the ALU result, which is the byte
    // address for loads and stores; store_data is the register value to store.
    typedef struct packed {
        logic [63:0] out;
        logic [63:0] store_data;
        mem_size_t   load_type;
        mem_size_t   store_type;
        logic        signed_byte;
        logic        signed_word;
        logic [4:0]  W_regnum;
        logic        write_enable;
        logic [63:0] pc4;
        logic        MFC0;
        logic        MTC0;
        logic        ERET;
        logic [2:0]  sel;
        logic        linkpc;
        logic        reserved_inst_E;
        logic        overflow;
    } EX_regs_t;

    typedef struct packed {
        logic [63:0] out;
        logic [4:0]  W_regnum;
        logic        write_enable;
        logic [63:0] pc4;
        logic        MFC0;
        logic        MTC0;
        logic        ERET;
        logic [2:0]  sel;
        logic        linkpc;
        logic        reserved_inst_E;
        logic        overflow;
        logic        addr_error;
    } MEM_regs_t;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(mem_size_t s);
        case (s)
            BYTE:    return 8'h01;
            HALF:    return 8'h03;
            WORD:    return 8'h0F;
            DWORD:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] low_mask(mem_size_t s);
        case (s)
            HALF:    return 3'b001;
            WORD:    return 3'b011;
            DWORD:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Store data copied into every lane of the access size so the memory
    // only needs the byte enables to pick the right bytes.
    function automatic logic [63:0] replicate_store(mem_size_t s, logic [63:0] d);
        case (s)
            BYTE:    return {8{d[7:0]}};
            HALF:    return {4{d[15:0]}};
            WORD:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    // Copy the fields that travel on to write-back, with a chosen result value.
    function automatic MEM_regs_t to_mem_regs(EX_regs_t e, logic [63:0] result, logic addrErr);
        MEM_regs_t m;
        m.out             = result;
        m.W_regnum        = e.W_regnum;
        m.write_enable    = e.write_enable;
        m.pc4             = e.pc4;
        m.MFC0            = e.MFC0;
        m.MTC0            = e.MTC0;
        m.ERET            = e.ERET;
        m.sel             = e.sel;
        m.linkpc          = e.linkpc;
        m.reserved_inst_E = e.reserved_inst_E;
        m.overflow        = e.overflow;
        m.addr_error      = addrErr;
        return m;
    endfunction

endpackage

// File: rtl/core_mem_load_align.sv
// Load data aligner for the memory stage.
// Shifts the addressed lane down to bit 0 and sign- or zero-extends it
// according to the access size and the signed_byte / signed_word controls.
module mem_load_align
    import core_mem_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_lane,
    input  mem_size_t   i_size,
    input  logic        i_signedByte,
    input  logic        i_signedWord,
    output logic [63:0] o_value
);

    logic [63:0] w_shifted;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};

    // Extend the shifted lane to 64 bits; byte and half share the byte sign control.
    always_comb begin
        o_value = w_shifted;
        case (i_size)
            BYTE:    o_value = i_signedByte ? {{56{w_shifted[7]}},  w_shifted[7:0]}
                                            : {56'b0, w_shifted[7:0]};
            HALF:    o_value = i_signedByte ? {{48{w_shifted[15]}}, w_shifted[15:0]}
                                            : {48'b0, w_shifted[15:0]};
            WORD:    o_value = i_signedWord ? {{32{w_shifted[31]}}, w_shifted[31:0]}
                                            : {32'b0, w_shifted[31:0]};
            default: o_value = w_shifted;
        endcase
    end

endmodule

// File: rtl/core_mem.sv
// Memory stage: takes EX_regs, issues at most one data-memory request per
// load/store over a req/ready handshake, stalls the front of the pipe while
// the request is outstanding, and produces MEM_regs / MEM_data.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned accesses
// with addr_error instead of silently aligning the address.
module core_mem
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  EX_regs_t          EX_regs,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [7:0]        dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              mem_stall,
    output logic [63:0]       MEM_data,
    output MEM_regs_t         MEM_regs
);

    mem_state_t  r_state;
    MEM_regs_t   r_memRegs;
    MEM_regs_t   r_hold;
    mem_size_t   r_holdLoad;
    logic        r_holdSignedByte;
    logic        r_holdSignedWord;
    logic        r_req;
    logic        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]  r_be;

    logic        w_isMem;
    mem_size_t   w_size;
    logic        w_addrErr;
    logic [63:0] w_issueAddr;
    logic        w_accept;
    logic [63:0] w_loadValue;
    MEM_regs_t   w_retire;

    assign w_isMem = (EX_regs.load_type != NONE) || (EX_regs.store_type != NONE);
    assign w_size  = (EX_regs.load_type != NONE) ? EX_regs.load_type : EX_regs.store_type;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misaligned;
    assign w_misaligned = |(EX_regs.out[2:0] & low_mask(w_size));
    assign w_addrErr    = w_isMem && w_misaligned;
    assign w_issueAddr  = EX_regs.out;
`else
    assign w_addrErr    = 1'b0;
    assign w_issueAddr  = {EX_regs.out[63:3], EX_regs.out[2:0] & ~low_mask(w_size)};
`endif

    assign w_accept  = (r_state == IDLE) && w_isMem && !flush && !w_addrErr;
    assign mem_stall = w_accept || ((r_state == BUSY) && !dmem_ready);

    mem_load_align u_align (
        .i_rdata      (dmem_rdata[63:0]),
        .i_lane       (r_hold.out[2:0]),
        .i_size       (r_holdLoad),
        .i_signedByte (r_holdSignedByte),
        .i_signedWord (r_holdSignedWord),
        .o_value      (w_loadValue)
    );

    // Result presented on completion: aligned load data, or the address for stores.
    always_comb begin
        w_retire     = r_hold;
        w_retire.out = (r_holdLoad != NONE) ? w_loadValue : r_hold.out;
    end

    // Two-state request FSM; all dmem_* outputs and MEM_regs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_memRegs        <= '0;
            r_hold           <= '0;
            r_holdLoad       <= NONE;
            r_holdSignedByte <= 1'b0;
            r_holdSignedWord <= 1'b0;
            r_req            <= 1'b0;
            r_we             <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_be             <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_memRegs <= EX_regs.linkpc ? to_mem_regs(EX_regs, EX_regs.out, 1'b0) : '0;
                    end else if (w_accept) begin
                        r_hold           <= to_mem_regs(EX_regs, w_issueAddr, 1'b0);
                        r_holdLoad       <= EX_regs.load_type;
                        r_holdSignedByte <= EX_regs.signed_byte;
                        r_holdSignedWord <= EX_regs.signed_word;
                        r_req            <= 1'b1;
                        r_we             <= (EX_regs.store_type != NONE);
                        r_addr           <= w_issueAddr[ADDR_W-1:0];
                        r_wdata          <= replicate_store(w_size, EX_regs.store_data);
                        r_be             <= size_mask(w_size) << w_issueAddr[2:0];
                        r_memRegs        <= '0;
                        r_state          <= BUSY;
                    end else begin
                        r_memRegs <= to_mem_regs(EX_regs, EX_regs.out, w_addrErr);
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        r_req     <= 1'b0;
                        r_memRegs <= w_retire;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign MEM_regs   = r_memRegs;
    assign MEM_data   = r_memRegs.out;

endmodule

// File: tb/tb_core_mem.sv
// Directed testbench for core_mem: ALU pass-through, loads with extension,
// replicated stores, flush handling, reset while busy, and the alignment
// behaviour selected by MEM_ALIGN_CHECK_EN.
module tb_core_mem;
    import core_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    EX_regs_t    EX_regs;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_rdata;
    logic        dmem_ready;
    logic        mem_stall;
    logic [63:0] MEM_data;
    MEM_regs_t   MEM_regs;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int stallCount = 0;

    EX_regs_t  ex;
    MEM_regs_t expRegs;

    core_mem #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .EX_regs    (EX_regs),
        .flush      (flush),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .mem_stall  (mem_stall),
        .MEM_data   (MEM_data),
        .MEM_regs   (MEM_regs)
    );

    always #5 clock = ~clock;

    // Hard time limit so the run always ends even if the design wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input EX_regs_t e, input logic fl);
        EX_regs = e;
        flush   = fl;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    function automatic EX_regs_t memOp(input logic [63:0] addr, input mem_size_t ld, input mem_size_t st,
                                       input logic [63:0] data, input logic sb, input logic sw,
                                       input logic [4:0] rd);
        EX_regs_t e;
        e             = '0;
        e.out         = addr;
        e.load_type   = ld;
        e.store_type  = st;
        e.store_data  = data;
        e.signed_byte = sb;
        e.signed_word = sw;
        e.W_regnum    = rd;
        e.write_enable = (ld != NONE);
        return e;
    endfunction

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        EX_regs    = '0;
        dmem_rdata = '0;
        dmem_ready = 1'b0;

        // Reset state
        stepClock();
        stepClock();
        checkOutput("reset_req",   dmem_req,  1'b0);
        checkOutput("reset_we",    dmem_we,   1'b0);
        checkOutput("reset_be",    dmem_be,   8'h00);
        checkOutput("reset_regs",  MEM_regs,  '0);
        checkOutput("reset_stall", mem_stall, 1'b0);
        reset = 1'b0;

        // ALU op: one-cycle pass-through, no stall
        ex              = '0;
        ex.out          = 64'h1234_5678_9ABC_DEF0;
        ex.W_regnum     = 5'd5;
        ex.write_enable = 1'b1;
        ex.pc4          = 64'h104;
        ex.sel          = 3'd2;
        ex.overflow     = 1'b1;
        applyStimulus(ex, 1'b0);
        #1;
        checkOutput("alu_stall", mem_stall, 1'b0);
        stepClock();
        expRegs              = '0;
        expRegs.out          = 64'h1234_5678_9ABC_DEF0;
        expRegs.W_regnum     = 5'd5;
        expRegs.write_enable = 1'b1;
        expRegs.pc4          = 64'h104;
        expRegs.sel          = 3'd2;
        expRegs.overflow     = 1'b1;
        checkOutput("alu_regs",     MEM_regs,  expRegs);
        checkOutput("alu_mem_data", MEM_data,  64'h1234_5678_9ABC_DEF0);
        checkOutput("alu_req",      dmem_req,  1'b0);
        checkOutput("alu_stall2",   mem_stall, 1'b0);

        // Signed byte load at 0x1003, memory answers after three waiting cycles
        applyStimulus(memOp(64'h1003, BYTE, NONE, 64'h0, 1'b1, 1'b0, 5'd7), 1'b0);
        stallCount = 0;
        #1;
        if (mem_stall) stallCount++;
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("lb_req",     dmem_req,  1'b1);
        checkOutput("lb_we",      dmem_we,   1'b0);
        checkOutput("lb_addr",    dmem_addr, 64'h1003);
        checkOutput("lb_be",      dmem_be,   8'h08);
        checkOutput("lb_regs_busy", MEM_regs, '0);
        for (int i = 0; i < 3; i++) begin
            if (mem_stall) stallCount++;
            stepClock();
        end
        dmem_rdata = 64'h1122_3344_8055_6677;
        dmem_ready = 1'b1;
        #1;
        if (mem_stall) stallCount++;
        checkOutput("lb_stall_cycles", stallCount, 4);
        stepClock();
        dmem_ready = 1'b0;
        checkOutput("lb_data",  MEM_data,          64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("lb_rd",    MEM_regs.W_regnum, 5'd7);
        checkOutput("lb_wen",   MEM_regs.write_enable, 1'b1);
        checkOutput("lb_req_drop", dmem_req,       1'b0);

        // Half store to 0x2006, memory ready in the same cycle as the request
        applyStimulus(memOp(64'h2006, NONE, HALF, 64'h1111_2222_3333_BEEF, 1'b0, 1'b0, 5'd0), 1'b0);
        #1;
        checkOutput("sh_stall_idle", mem_stall, 1'b1);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("sh_req",   dmem_req,   1'b1);
        checkOutput("sh_we",    dmem_we,    1'b1);
        checkOutput("sh_addr",  dmem_addr,  64'h2006);
        checkOutput("sh_be",    dmem_be,    8'hC0);
        checkOutput("sh_wdata", dmem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        dmem_ready = 1'b1;
        #1;
        checkOutput("sh_stall_ready", mem_stall, 1'b0);
        stepClock();
        dmem_ready = 1'b0;
        checkOutput("sh_req_drop", dmem_req, 1'b0);
        checkOutput("sh_out_addr", MEM_data, 64'h2006);

        // Misaligned word load at 0x3002, issued back-to-back after the store
        applyStimulus(memOp(64'h3002, WORD, NONE, 64'h0, 1'b0, 1'b0, 5'd9), 1'b0);
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("lw_mis_stall", mem_stall, 1'b0);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("lw_mis_req",   dmem_req,            1'b0);
        checkOutput("lw_mis_err",   MEM_regs.addr_error, 1'b1);
        checkOutput("lw_mis_out",   MEM_data,            64'h3002);
`else
        checkOutput("lw_b2b_stall", mem_stall, 1'b1);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("lw_req",  dmem_req,  1'b1);
        checkOutput("lw_addr", dmem_addr, 64'h3000);
        checkOutput("lw_be",   dmem_be,   8'h0F);
        dmem_rdata = 64'hAAAA_AAAA_8765_4321;
        dmem_ready = 1'b1;
        stepClock();
        dmem_ready = 1'b0;
        checkOutput("lw_data", MEM_data,            64'h0000_0000_8765_4321);
        checkOutput("lw_err",  MEM_regs.addr_error, 1'b0);
`endif

        // Signed half load from lane 6
        applyStimulus(memOp(64'h4006, HALF, NONE, 64'h0, 1'b1, 1'b0, 5'd3), 1'b0);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("lh_be", dmem_be, 8'hC0);
        dmem_rdata = 64'h8001_5555_6666_7777;
        dmem_ready = 1'b1;
        stepClock();
        dmem_ready = 1'b0;
        checkOutput("lh_data", MEM_data, 64'hFFFF_FFFF_FFFF_8001);

        // Flush of a pending load: no request, bubble into MEM_regs
        applyStimulus(memOp(64'h5000, DWORD, NONE, 64'h0, 1'b0, 1'b0, 5'd4), 1'b1);
        #1;
        checkOutput("flush_stall", mem_stall, 1'b0);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("flush_req",  dmem_req, 1'b0);
        checkOutput("flush_regs", MEM_regs, '0);

        // Flush with linkpc: the link value still reaches write-back
        ex              = memOp(64'h6000, WORD, NONE, 64'h0, 1'b0, 1'b0, 5'd31);
        ex.linkpc       = 1'b1;
        ex.pc4          = 64'h700;
        applyStimulus(ex, 1'b1);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("link_req",    dmem_req,          1'b0);
        checkOutput("link_pc4",    MEM_regs.pc4,      64'h700);
        checkOutput("link_flag",   MEM_regs.linkpc,   1'b1);
        checkOutput("link_rd",     MEM_regs.W_regnum, 5'd31);

        // Asynchronous reset while a request is outstanding
        applyStimulus(memOp(64'h8000, DWORD, NONE, 64'h0, 1'b0, 1'b0, 5'd2), 1'b0);
        stepClock();
        applyStimulus('0, 1'b0);
        checkOutput("rstbusy_req_before", dmem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstbusy_req",   dmem_req,  1'b0);
        checkOutput("rstbusy_be",    dmem_be,   8'h00);
        checkOutput("rstbusy_regs",  MEM_regs,  '0);
        checkOutput("rstbusy_stall", mem_stall, 1'b0);
        stepClock();
        reset = 1'b0;

        // Plain op after reset proves the FSM is back in IDLE
        ex          = '0;
        ex.out      = 64'hCAFE;
        applyStimulus(ex, 1'b0);
        stepClock();
        checkOutput("post_reset_alu", MEM_data, 64'hCAFE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
